// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
//   Shared types and constants for the APB master arbiter.
//   - arb_state_e : transfer sequencer states (IDLE -> SETUP -> ACCESS)
//   - RDATA_ABORT : fill bit for read data returned on an aborted transfer
//   - idx_width   : width of a requester index (at least 1 bit)
// ---------------------------------------------------------------------------
package apb_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_SETUP  = 2'd1,
      ARB_ACCESS = 2'd2
   } arb_state_e;

   // Replicated to the data width wherever it is used, so it fits any width.
   localparam bit RDATA_ABORT = 1'b0;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Pure combinational round-robin pick. The first requester found at or
//   after the pointer (wrapping around) wins.
//   Ports:
//     i_req   [N]  request vector
//     i_ptr   [PW] round-robin pointer (held in the parent)
//     o_gnt   [N]  one-hot winner (all zero when no request)
//     o_idx   [PW] binary index of the winner
//     o_valid      at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
   import apb_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]              i_req,
   input  logic [idx_width(N)-1:0]   i_ptr,
   output logic [N-1:0]              o_gnt,
   output logic [idx_width(N)-1:0]   o_idx,
   output logic                      o_valid
);

   localparam int PW = idx_width(N);

   logic [N-1:0] w_mask;
   logic [N-1:0] w_hi;
   logic [N-1:0] w_sel;

   // Requests at or above the pointer take priority; if none, fall back to
   // the whole vector, which is the wrap-around case. Isolating the lowest
   // set bit of the chosen vector then gives the winner.
   assign w_mask  = {N{1'b1}} << i_ptr;
   assign w_hi    = i_req & w_mask;
   assign w_sel   = (w_hi != '0) ? w_hi : i_req;
   assign o_gnt   = w_sel & (~w_sel + N'(1));
   assign o_valid = |i_req;

   always_comb begin
      o_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (o_gnt[i]) o_idx = PW'(i);
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
//   Shares one APB master port among NB_REQ requesters. A round-robin winner
//   is granted in IDLE, its request is captured, then driven through the APB
//   SETUP and ACCESS phases. The completion (read data + error) comes back to
//   the owner as a one-cycle rvalid pulse the cycle after ACCESS ends.
//
//   Optional feature macro: APB_ARB_TIMEOUT_EN
//     defined   : ACCESS is aborted after TIMEOUT_CYCLES cycles without pready;
//                 the owner gets rvalid with err_o=1 and rdata_o=0.
//     undefined : ACCESS waits for pready indefinitely.
//
//   Handshake: a requester raises req_i with addr/we/wdata and holds them
//   until it sees its gnt_o bit (a one-cycle pulse). Inputs after the grant
//   are ignored. Exactly one rvalid_o pulse follows each grant unless reset
//   intervenes. Dropping req_i before a grant simply withdraws the request.
//
//   Ports:
//     HCLK, HRESETn          clock, synchronous active-low reset
//     req_i/addr_i/we_i/wdata_i  per-requester request (flattened buses)
//     gnt_o, rvalid_o        one-hot grant / completion pulses
//     rdata_o, err_o         completion data, valid with rvalid_o
//     paddr/pwdata/pwrite/psel/penable  APB master outputs
//     prdata/pready/pslverr  APB slave responses
//     dbg_state_o            current sequencer state (observation only)
// ---------------------------------------------------------------------------
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NB_REQ         = 4,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                               HCLK,
   input  logic                               HRESETn,
   input  logic [NB_REQ-1:0]                  req_i,
   input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   addr_i,
   input  logic [NB_REQ-1:0]                  we_i,
   input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   wdata_i,
   output logic [NB_REQ-1:0]                  gnt_o,
   output logic [NB_REQ-1:0]                  rvalid_o,
   output logic [APB_DATA_WIDTH-1:0]          rdata_o,
   output logic                               err_o,
   output logic [APB_ADDR_WIDTH-1:0]          paddr,
   output logic [APB_DATA_WIDTH-1:0]          pwdata,
   output logic                               pwrite,
   output logic                               psel,
   output logic                               penable,
   input  logic [APB_DATA_WIDTH-1:0]          prdata,
   input  logic                               pready,
   input  logic                               pslverr,
   output arb_state_e                         dbg_state_o
);

   localparam int PW = idx_width(NB_REQ);
   localparam int AW = APB_ADDR_WIDTH;
   localparam int DW = APB_DATA_WIDTH;

   // A zero limit would make the abort compare meaningless; legal
   // configurations never elaborate this block.
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_bad
   end

   arb_state_e            r_state;
   arb_state_e            w_next_state;
   logic [PW-1:0]         r_ptr;
   logic [PW-1:0]         r_owner;
   logic [AW-1:0]         r_addr;
   logic [DW-1:0]         r_wdata;
   logic                  r_we;
   logic [NB_REQ-1:0]     r_rvalid;
   logic [DW-1:0]         r_rdata;
   logic                  r_err;

   logic [NB_REQ-1:0]     w_gnt;
   logic [PW-1:0]         w_idx;
   logic                  w_any;
   logic                  w_grant_en;
   logic                  w_complete;
   logic                  w_abort;
   logic [AW-1:0]         w_sel_addr;
   logic [DW-1:0]         w_sel_wdata;
   logic                  w_sel_we;
   logic [NB_REQ-1:0]     w_owner_oh;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0]         r_cnt;
`endif

   rr_arbiter #(.N(NB_REQ)) u_rr (
      .i_req   (req_i),
      .i_ptr   (r_ptr),
      .o_gnt   (w_gnt),
      .o_idx   (w_idx),
      .o_valid (w_any)
   );

   // Request fields of the current winner.
   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_we    = 1'b0;
      for (int k = 0; k < NB_REQ; k++) begin
         if (w_idx == PW'(k)) begin
            w_sel_addr  = addr_i[k*AW +: AW];
            w_sel_wdata = wdata_i[k*DW +: DW];
            w_sel_we    = we_i[k];
         end
      end
   end

   assign w_owner_oh = NB_REQ'(1) << r_owner;

   // ---------------- sequencer: state register ----------------
   always_ff @(posedge HCLK) begin
      if (!HRESETn) r_state <= ARB_IDLE;
      else          r_state <= w_next_state;
   end

   // ---------------- sequencer: next state / strobes ----------------
   always_comb begin
      w_next_state = r_state;
      w_grant_en   = 1'b0;
      w_complete   = 1'b0;
      w_abort      = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_any) begin
               w_grant_en   = 1'b1;
               w_next_state = ARB_SETUP;
            end
         end
         ARB_SETUP: begin
            w_next_state = ARB_ACCESS;
         end
         ARB_ACCESS: begin
            if (pready) begin
               w_complete   = 1'b1;
               w_next_state = ARB_IDLE;
            end
`ifdef APB_ARB_TIMEOUT_EN
            // r_cnt counts completed ACCESS cycles, so it equals LIMIT-1
            // during the LIMIT-th ACCESS cycle.
            else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               w_abort      = 1'b1;
               w_next_state = ARB_IDLE;
            end
`endif
         end
         default: begin
            w_next_state = ARB_IDLE;
         end
      endcase
   end

   // ---------------- request capture, pointer, completion ----------------
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_ptr    <= '0;
         r_owner  <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_we     <= 1'b0;
         r_rvalid <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         // Completion outputs are pulses; cleared unless set below.
         r_rvalid <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
         if (w_grant_en) begin
            r_owner <= w_idx;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_we    <= w_sel_we;
            r_ptr   <= (w_idx == PW'(NB_REQ - 1)) ? '0 : w_idx + PW'(1);
         end
         if (w_complete) begin
            r_rvalid <= w_owner_oh;
            r_rdata  <= r_we ? '0 : prdata;
            r_err    <= pslverr;
         end
         if (w_abort) begin
            r_rvalid <= w_owner_oh;
            r_rdata  <= {DW{RDATA_ABORT}};
            r_err    <= 1'b1;
         end
      end
   end

`ifdef APB_ARB_TIMEOUT_EN
   always_ff @(posedge HCLK) begin
      if (!HRESETn)                  r_cnt <= '0;
      else if (w_grant_en)           r_cnt <= '0;
      else if (r_state == ARB_ACCESS) r_cnt <= r_cnt + CW'(1);
   end
`endif

   assign gnt_o       = w_grant_en ? w_gnt : '0;
   assign rvalid_o    = r_rvalid;
   assign rdata_o     = r_rdata;
   assign err_o       = r_err;
   assign paddr       = r_addr;
   assign pwdata      = r_wdata;
   assign pwrite      = r_we;
   assign psel        = (r_state != ARB_IDLE);
   assign penable     = (r_state == ARB_ACCESS);
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;
   import apb_arb_pkg::*;

   localparam int NB = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   // ---------------- clock / reset ----------------
   logic HCLK    = 1'b0;
   logic HRESETn = 1'b0;
   always #5 HCLK = ~HCLK;

   logic [NB-1:0]    req_i   = '0;
   logic [NB*AW-1:0] addr_i  = '0;
   logic [NB-1:0]    we_i    = '0;
   logic [NB*DW-1:0] wdata_i = '0;
   logic [DW-1:0]    prdata  = '0;
   logic             pready  = 1'b0;
   logic             pslverr = 1'b0;

   logic [NB-1:0]    gnt_o;
   logic [NB-1:0]    rvalid_o;
   logic [DW-1:0]    rdata_o;
   logic             err_o;
   logic [AW-1:0]    paddr;
   logic [DW-1:0]    pwdata;
   logic             pwrite;
   logic             psel;
   logic             penable;
   arb_state_e       dbg_state_o;

   apb_master_arbiter #(
      .NB_REQ(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i),
      .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
      .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .dbg_state_o(dbg_state_o)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // ---------------- scoreboard: {owner one-hot, err, rdata} ----------------
   logic [NB+DW:0] exp_q[$];

   always @(negedge HCLK) begin
      if (rvalid_o != '0) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_rvalid", {rvalid_o, err_o, rdata_o}, '0);
         end else begin
            check("sb_resp", {rvalid_o, err_o, rdata_o}, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive_req(input int k, input logic [AW-1:0] a, input logic w,
                            input logic [DW-1:0] d);
      req_i[k]            = 1'b1;
      addr_i[k*AW +: AW]  = a;
      we_i[k]             = w;
      wdata_i[k*DW +: DW] = d;
   endtask

   task automatic expect_resp(input int k, input logic e, input logic [DW-1:0] d);
      logic [NB-1:0] oh;
      oh = '0;
      oh[k] = 1'b1;
      exp_q.push_back({oh, e, d});
   endtask

   task automatic apply_reset();
      HRESETn = 1'b0;
      req_i   = '0;
      pready  = 1'b0;
      pslverr = 1'b0;
      step();
      step();
      HRESETn = 1'b1;
      exp_q.delete();
   endtask

   int order [5] = '{0, 1, 2, 3, 0};

   initial begin
      // ---------------- reset state ----------------
      step();
      step();
      check("rst_psel",    psel,        1'b0);
      check("rst_penable", penable,     1'b0);
      check("rst_pwrite",  pwrite,      1'b0);
      check("rst_paddr",   paddr,       '0);
      check("rst_pwdata",  pwdata,      '0);
      check("rst_gnt",     gnt_o,       '0);
      check("rst_rvalid",  rvalid_o,    '0);
      check("rst_rdata",   rdata_o,     '0);
      check("rst_err",     err_o,       1'b0);
      check("rst_state",   dbg_state_o, ARB_IDLE);
      HRESETn = 1'b1;
      step();

      // ---------------- 1: single write, zero wait states ----------------
      drive_req(0, 32'h1A10_0004, 1'b1, 32'hCAFE_F00D);
      pready = 1'b1;
      #1;
      check("t1_gnt",  gnt_o, 4'b0001);
      check("t1_psel_idle", psel, 1'b0);
      expect_resp(0, 1'b0, '0);
      step();
      req_i = '0;
      #1;
      check("t1_setup_psel",    psel,    1'b1);
      check("t1_setup_penable", penable, 1'b0);
      check("t1_setup_paddr",   paddr,   32'h1A10_0004);
      check("t1_setup_pwdata",  pwdata,  32'hCAFE_F00D);
      check("t1_setup_pwrite",  pwrite,  1'b1);
      check("t1_setup_gnt",     gnt_o,   '0);
      check("t1_setup_state",   dbg_state_o, ARB_SETUP);
      step();
      check("t1_access_psel",    psel,    1'b1);
      check("t1_access_penable", penable, 1'b1);
      check("t1_access_paddr",   paddr,   32'h1A10_0004);
      step();
      check("t1_rvalid", rvalid_o, 4'b0001);
      check("t1_err",    err_o,    1'b0);
      check("t1_rdata",  rdata_o,  '0);
      check("t1_psel_done", psel,  1'b0);
      step();
      check("t1_rvalid_pulse", rvalid_o, '0);

      // ---------------- 2: read, 3 wait states; withdrawn request ----------------
      drive_req(1, 32'h1A10_0008, 1'b0, '0);
      pready = 1'b0;
      prdata = 32'h1234_5678;
      #1;
      check("t2_gnt", gnt_o, 4'b0010);
      expect_resp(1, 1'b0, 32'h1234_5678);
      step();
      req_i = '0;
      step();
      for (int i = 0; i < 4; i++) begin
         check("t2_penable", penable, 1'b1);
         check("t2_paddr",   paddr,   32'h1A10_0008);
         check("t2_pwrite",  pwrite,  1'b0);
         check("t2_rvalid_wait", rvalid_o, '0);
         if (i == 1) drive_req(3, 32'h1A10_00F0, 1'b0, '0);
         if (i == 2) req_i = '0;
         if (i == 3) pready = 1'b1;
         step();
      end
      check("t2_rvalid", rvalid_o, 4'b0010);
      check("t2_rdata",  rdata_o,  32'h1234_5678);
      check("t2_no_gnt_withdrawn", gnt_o, '0);
      step();

      // ---------------- 3: all requesting, round-robin order ----------------
      apply_reset();
      step();
      for (int k = 0; k < NB; k++) drive_req(k, 32'h4000_0000 + 32'(k * 16), 1'b0, '0);
      pready = 1'b1;
      for (int g = 0; g < 5; g++) begin
         prdata = 32'hA000_0000 | 32'(g);
         #1;
         check("t3_gnt", gnt_o, 64'(1) << order[g]);
         if (g > 0) check("t3_rvalid_prev", rvalid_o, 64'(1) << order[g-1]);
         expect_resp(order[g], 1'b0, 32'hA000_0000 | 32'(g));
         step();
         check("t3_setup_gnt",   gnt_o, '0);
         check("t3_setup_paddr", paddr, 32'h4000_0000 + 32'(order[g] * 16));
         step();
         check("t3_access_gnt", gnt_o, '0);
         step();
      end
      req_i = '0;
      #1;
      check("t3_rvalid_last", rvalid_o, 4'b0001);
      check("t3_gnt_idle",    gnt_o,    '0);
      step();

      // ---------------- 4: slave error, then clean transfer ----------------
      drive_req(0, 32'h1A10_0100, 1'b0, '0);
      pslverr = 1'b1;
      prdata  = 32'hDEAD_0001;
      #1;
      check("t4_gnt", gnt_o, 4'b0001);
      expect_resp(0, 1'b1, 32'hDEAD_0001);
      step();
      req_i = '0;
      step();
      step();
      check("t4_err",   err_o,   1'b1);
      check("t4_rdata", rdata_o, 32'hDEAD_0001);
      pslverr = 1'b0;
      prdata  = 32'h0000_0BEE;
      drive_req(1, 32'h1A10_0104, 1'b0, '0);
      #1;
      check("t4_gnt2", gnt_o, 4'b0010);
      expect_resp(1, 1'b0, 32'h0000_0BEE);
      step();
      req_i = '0;
      step();
      step();
      check("t4_err_clear", err_o,   1'b0);
      check("t4_rdata2",    rdata_o, 32'h0000_0BEE);
      step();

      // ---------------- 5: reset during ACCESS ----------------
      drive_req(3, 32'h1A10_0200, 1'b1, 32'h0000_0055);
      pready = 1'b0;
      #1;
      check("t5_gnt", gnt_o, 4'b1000);
      step();
      req_i = '0;
      step();
      check("t5_in_access", penable, 1'b1);
      HRESETn = 1'b0;
      step();
      check("t5_rst_psel",    psel,        1'b0);
      check("t5_rst_penable", penable,     1'b0);
      check("t5_rst_rvalid",  rvalid_o,    '0);
      check("t5_rst_state",   dbg_state_o, ARB_IDLE);
      HRESETn = 1'b1;
      pready  = 1'b1;
      step();
      check("t5_no_rvalid", rvalid_o, '0);
      prdata = 32'h0000_0C0C;
      drive_req(2, 32'h1A10_0300, 1'b0, '0);
      #1;
      check("t5_gnt_after", gnt_o, 4'b0100);
      expect_resp(2, 1'b0, 32'h0000_0C0C);
      step();
      req_i = '0;
      check("t5_paddr", paddr, 32'h1A10_0300);
      step();
      step();
      check("t5_rvalid", rvalid_o, 4'b0100);
      step();

`ifdef APB_ARB_TIMEOUT_EN
      // ---------------- 6: ACCESS timeout ----------------
      drive_req(0, 32'h1A10_0400, 1'b0, '0);
      pready = 1'b0;
      prdata = 32'hFFFF_FFFF;
      #1;
      check("t6_gnt", gnt_o, 4'b0001);
      expect_resp(0, 1'b1, '0);
      step();
      req_i = '0;
      step();
      for (int i = 0; i < 8; i++) begin
         check("t6_penable_held", penable, 1'b1);
         check("t6_no_rvalid",    rvalid_o, '0);
         step();
      end
      check("t6_psel_drop", psel,     1'b0);
      check("t6_rvalid",    rvalid_o, 4'b0001);
      check("t6_err",       err_o,    1'b1);
      check("t6_rdata",     rdata_o,  '0);
      step();
`endif

      step();
      check("sb_drain", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
